btn_gesture: RTL and testbench

Button gesture classifier: a clocked state machine that turns the debounced press level of one switch into single-click, double-click, long-press and auto-repeat event pulses. It sits directly downstream of the switch driver and consumes that driver's debounced level output. Its event pulses feed UI/menu logic, so that logic never times presses itself.

---
 rtl/btn_gesture.sv | 157 +++++++++++++++
 tb/tb_btn_gesture.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/btn_gesture.sv
// btn_gesture: turns the debounced level of one switch into single-click,
// double-click, long-press and auto-repeat event pulses.
//
// The design has one state register and one shared timer. The timer restarts
// from zero each time the state changes. It also restarts on every repeat tick
// while in HOLD. Every output comes from a flop that is loaded on the same edge
// as the state change, so UI logic downstream gets clean one-cycle pulses with
// no decode glitches.
module btn_gesture #(
    parameter int unsigned p_long   = 25_000_000,  // long-press hold, cycles (>= 2)
    parameter int unsigned p_gap    = 12_500_000,  // double-click window, cycles (>= 1)
    parameter int unsigned p_repeat = 5_000_000    // repeat period, cycles (0 = off)
) (
    input  logic       i_clk,
    input  logic       i_rst,     // asynchronous, active low
    input  logic       i_press,   // debounced level, 1 = pressed
    input  logic       i_en,      // 0 aborts any gesture back to IDLE
    output logic       o_single,
    output logic       o_double,
    output logic       o_long,
    output logic       o_repeat,
    output logic       o_held,
    output logic [2:0] o_state
);

    // The timer must hold the largest terminal count in use.
    localparam int unsigned P_LG  = (p_long > p_gap) ? p_long : p_gap;
    localparam int unsigned P_MAX = (P_LG > p_repeat) ? P_LG : p_repeat;
    localparam int unsigned TW    = (P_MAX < 1) ? 1 : $clog2(P_MAX + 1);

    // Terminal counts. The timer counts 0..N-1, so an event that is N cycles
    // after state entry fires on the edge where the timer equals N-1.
    localparam logic [TW-1:0] LONG_END = TW'(p_long - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(p_gap - 1);
    localparam logic [TW-1:0] REP_END  = TW'((p_repeat == 0) ? 0 : p_repeat - 1);
    localparam bit            REP_ON   = (p_repeat != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOWN1 = 3'd1,
        HOLD  = 3'd2,
        GAP   = 3'd3,
        DOWN2 = 3'd4
    } state_e;

    state_e        state_q,  state_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic          single_q, single_d;
    logic          double_q, double_d;
    logic          long_q,   long_d;
    logic          repeat_q, repeat_d;
    logic          held_q,   held_d;

    logic long_hit;
    logic gap_hit;
    logic rep_hit;

    // Terminal-count decodes. Each one is used only in its own state.
    assign long_hit = (timer_q == LONG_END);
    assign gap_hit  = (timer_q == GAP_END);
    assign rep_hit  = REP_ON && (timer_q == REP_END);

    // Next-state, timer and event decision. Release or re-press is always
    // tested before the timeout, so a same-edge tie resolves toward the
    // button level.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        if (!i_en) begin
            // An abort drops the gesture silently, even from IDLE.
            state_d = IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_press) state_d = DOWN1;
                end
                DOWN1: begin
                    if (!i_press) begin
                        state_d = GAP;
                    end else if (long_hit) begin
                        state_d = HOLD;
                        long_d  = 1'b1;
                    end
                end
                HOLD: begin
                    if (!i_press) begin
                        state_d = IDLE;
                    end else if (rep_hit) begin
                        // Stay in HOLD. Restart the timer so ticks are periodic.
                        repeat_d = 1'b1;
                        timer_d  = '0;
                    end
                end
                GAP: begin
                    if (i_press) begin
                        state_d = DOWN2;
                    end else if (gap_hit) begin
                        state_d  = IDLE;
                        single_d = 1'b1;
                    end
                end
                DOWN2: begin
                    // No timeout here. A slow second press is still a double.
                    if (!i_press) begin
                        state_d  = IDLE;
                        double_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Every state entry starts the timer from zero.
            if (state_d != state_q) timer_d = '0;
        end

        // The held flag is registered alongside the state, so it lines up
        // exactly with o_state == HOLD.
        held_d = (state_d == HOLD);
    end

    // State, timer and registered outputs. Reset discards any pending gesture.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign o_single = single_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_held   = held_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_btn_gesture.sv
// Scoreboard bench for btn_gesture.
//
// The stimulus process drives one input pattern per cycle. It then advances a
// reference model and queues the output vector expected after the next
// rising edge. The model tracks phases by absolute edge number and measures
// durations by subtraction: a press held for P_LONG edges is long, and a
// release followed by P_GAP quiet edges is a single click. A separate monitor
// pops one entry after each rising edge, and after each asynchronous reset
// assertion, and compares it with the DUT outputs.
module tb_btn_gesture;

    localparam int unsigned P_LONG   = 8;
    localparam int unsigned P_GAP    = 4;
    localparam int unsigned P_REPEAT = 3;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_press = 1'b0;
    logic       i_en = 1'b1;
    logic       o_single, o_double, o_long, o_repeat, o_held;
    logic [2:0] o_state;

    btn_gesture #(
        .p_long  (P_LONG),
        .p_gap   (P_GAP),
        .p_repeat(P_REPEAT)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_press (i_press),
        .i_en    (i_en),
        .o_single(o_single),
        .o_double(o_double),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_held  (o_held),
        .o_state (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Expected vector layout: {state[2:0], held, single, double, long, repeat}.
    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    // Reference model state. Only the stimulus process writes these.
    int m_phase = 0;  // 0 idle, 1 first press, 2 hold, 3 gap, 4 second press
    int m_mark  = 0;  // edge number of the last phase entry or repeat tick
    int edge_no = 0;
    bit m_s, m_d, m_l, m_r;

    function automatic logic [7:0] model_vec();
        return {3'(m_phase), (m_phase == 2), m_s, m_d, m_l, m_r};
    endfunction

    task automatic enter(input int ph);
        m_phase = ph;
        m_mark  = edge_no;
    endtask

    // Apply the gesture rules for the edge that samples (p, en).
    task automatic model_edge(input bit p, input bit en);
        int age;
        edge_no++;
        age = edge_no - m_mark;
        {m_s, m_d, m_l, m_r} = 4'b0;
        if (!en) begin
            enter(0);
        end else begin
            case (m_phase)
                0: if (p) enter(1);
                1: if (!p) enter(3);
                   else if (age == P_LONG) begin enter(2); m_l = 1; end
                2: if (!p) enter(0);
                   else if (P_REPEAT != 0 && age == P_REPEAT) begin m_r = 1; m_mark = edge_no; end
                3: if (p) enter(4);
                   else if (age == P_GAP) begin enter(0); m_s = 1; end
                4: if (!p) begin enter(0); m_d = 1; end
                default: enter(0);
            endcase
        end
    endtask

    // One cycle with reset released.
    task automatic drive(input bit p, input bit en);
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_press = p;
        i_en    = en;
        model_edge(p, en);
        exp_q.push_back(model_vec());
    endtask

    // One cycle held in reset. The input level is random because it must be ignored.
    task automatic drive_rst();
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_press = 1'($urandom_range(0, 1));
        enter(0);
        {m_s, m_d, m_l, m_r} = 4'b0;
        exp_q.push_back(model_vec());
    endtask

    // Assert reset between edges. The outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        @(posedge i_clk);
        #3;
        enter(0);
        {m_s, m_d, m_l, m_r} = 4'b0;
        exp_q.push_back(model_vec());
        i_rst = 1'b0;
    endtask

    task automatic run(input bit p, input int n);
        for (int k = 0; k < n; k++) drive(p, 1'b1);
    endtask

    // Monitor: after every rising edge or reset assertion, check the oldest expectation.
    initial begin
        logic [7:0] e, a;
        forever begin
            @(posedge i_clk or negedge i_rst);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {o_state, o_held, o_single, o_double, o_long, o_repeat};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs t=%0t: got st=%0d held=%b s=%b d=%b l=%b r=%b, want st=%0d held=%b s=%b d=%b l=%b r=%b",
                             $time, a[7:5], a[4], a[3], a[2], a[1], a[0],
                             e[7:5], e[4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int lvl;
        int n;
        // Reset state.
        drive_rst();
        drive_rst();

        // Short press: o_single comes 4 cycles after the release edge.
        run(1, 3); run(0, 8);
        // Double click.
        run(1, 2); run(0, 2); run(1, 2); run(0, 4);
        // Long hold with repeats.
        run(1, 20); run(0, 4);
        // Release exactly when the first-press timer reaches 7: no long press.
        run(1, 8); run(0, 7);
        // Re-press exactly when the gap timer reaches 3: double click.
        run(1, 2); run(0, 4); run(1, 2); run(0, 3);

        // Async reset mid-gap: no stale single afterwards.
        run(1, 2); run(0, 2);
        async_reset(); drive_rst(); run(0, 8);
        // Async reset mid-hold: no stale repeat afterwards.
        run(1, 12);
        async_reset(); drive_rst(); drive_rst(); run(0, 6);

        // Enable drop during the second press: no double. Re-enable with the
        // button held, which starts a new press.
        run(1, 2); run(0, 2); run(1, 2);
        drive(1, 1'b0);
        run(1, 2); run(0, 8);

        // Randomized press/release runs with occasional enable drops.
        lvl = 0;
        for (int r = 0; r < 80; r++) begin
            lvl = 1 - lvl;
            n = $urandom_range(1, 13);
            for (int k = 0; k < n; k++)
                drive(lvl[0], ($urandom_range(0, 24) != 0));
        end
        run(0, 8);

        // Wait for the scoreboard to drain, with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge i_clk);
        #2;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
